// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one uart_tx, with a launch timeout.
// Define UART_ARB_FIXED_PRIO_EN to make the lowest-index request always win (the pointer then stays 0).
module uart_tx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int LAUNCH_TO = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           tx_data,
    output logic                 tx_write_en,
    input  logic                 tx_rdy,
    output logic                 busy,
    output logic [2:0]           owner,
    output logic                 err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);
    localparam logic [7:0]         TO_LAST  = 8'(LAUNCH_TO - 1);

    state_t               state;
    logic [2:0]           ptr;
    logic [7:0]           timer;
    logic [2:0]           winner;
    logic                 found;
    logic [3:0]           cand;
    logic [NUM_REQ-1:0]   req_rot;
    logic [3:0]           inc;
    logic [2:0]           next_ptr;
    logic [7:0]           win_byte;

    // Search upward from ptr with wrap; in fixed-priority builds ptr is held at 0,
    // so the same search simply picks the lowest set request.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        cand    = '0;
        req_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + 4'(i);
            if (cand >= 4'(NUM_REQ)) begin
                cand = cand - 4'(NUM_REQ);
            end
            req_rot = req >> cand;
            if (!found && req_rot[0]) begin
                winner = cand[2:0];
                found  = 1'b1;
            end
        end
    end

    assign win_byte = 8'(req_data >> {winner, 3'b000});
    assign inc      = {1'b0, winner} + 4'd1;

`ifdef UART_ARB_FIXED_PRIO_EN
    assign next_ptr = 3'd0;
`else
    assign next_ptr = (inc >= 4'(NUM_REQ)) ? 3'd0 : inc[2:0];
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            tx_data     <= '0;
            tx_write_en <= 1'b0;
            gnt         <= '0;
            err         <= 1'b0;
            timer       <= '0;
        end else begin
            gnt <= '0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_rdy && found) begin
                        gnt         <= ONE_HOT0 << winner;
                        tx_data     <= win_byte;
                        owner       <= winner;
                        ptr         <= next_ptr;
                        tx_write_en <= 1'b1;
                        timer       <= '0;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!tx_rdy) begin
                        tx_write_en <= 1'b0;
                        state       <= WAIT_DONE;
                    end else if (timer == TO_LAST) begin
                        // The transmitter never took the byte: drop it, keep the advanced pointer.
                        tx_write_en <= 1'b0;
                        err         <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (tx_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: grants are predicted into a queue and checked by a monitor,
// with a small uart_tx model that drops tx_rdy for a fixed frame after each write strobe.
module tb_uart_tx_arb;

    localparam int FRAME = 12;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_write_en;
    logic        tx_rdy;
    logic        busy;
    logic [2:0]  owner;
    logic        err;

    typedef struct packed {
        logic [3:0] g;
        logic [7:0] d;
        logic [2:0] o;
    } exp_t;

    exp_t sb[$];
    int   pass_count  = 0;
    int   total_count = 0;
    int   gnt_seen    = 0;
    logic auto_drop   = 1'b1;
    logic model_on    = 1'b1;
    int   frame_cnt   = 0;

    uart_tx_arb #(.NUM_REQ(4), .LAUNCH_TO(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .tx_data(tx_data),
        .tx_write_en(tx_write_en),
        .tx_rdy(tx_rdy),
        .busy(busy),
        .owner(owner),
        .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge clk);
        #1;
        req = r;
    endtask

    task automatic push_exp(input logic [3:0] g, input logic [7:0] d, input logic [2:0] o);
        exp_t e;
        e.g = g;
        e.d = d;
        e.o = o;
        sb.push_back(e);
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_wait_done(input string name, input int budget);
        int n = 0;
        while (!(busy && !tx_write_en) && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput(name, 32'(busy && !tx_write_en), 32'd1);
    endtask

    // uart_tx model: a write strobe seen while idle starts a frame of FRAME cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (frame_cnt > 0) begin
                    frame_cnt--;
                    if (frame_cnt == 0) tx_rdy = 1'b1;
                end else if (tx_rdy && tx_write_en) begin
                    tx_rdy    = 1'b0;
                    frame_cnt = FRAME;
                end
            end
        end
    end

    // Monitor: every grant pulse must match the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && gnt != 4'b0000) begin
                gnt_seen++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_gnt", 32'(gnt), 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("gnt", 32'(gnt), 32'(e.g));
                    checkOutput("tx_data_on_gnt", 32'(tx_data), 32'(e.d));
                    checkOutput("owner_on_gnt", 32'(owner), 32'(e.o));
                    checkOutput("we_on_gnt", 32'(tx_write_en), 32'd1);
                    checkOutput("err_with_gnt", 32'(err), 32'd0);
                    checkOutput("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                end
                if (auto_drop) req = req & ~gnt;
            end
        end
    end

    initial begin
        int g0;
        int we_cnt;
        int err_cnt;
        int n;

        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = 32'h0;
        tx_rdy   = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_we", 32'(tx_write_en), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_owner", 32'(owner), 32'd0);
        checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Single request, byte 0x5A
        req_data = 32'h0000_005A;
        push_exp(4'b0001, 8'h5A, 3'd0);
        applyStimulus(4'b0001);
        wait_sb_empty("drain_single", 20);
        wait_wait_done("reach_wait_single", 20);
        checkOutput("single_hold_data", 32'(tx_data), 32'h5A);
        checkOutput("single_owner", 32'(owner), 32'd0);
        wait_idle("idle_single", 40);

        // All four held: rotating order from a freshly reset pointer
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        req_data  = 32'h4332_2110;
        auto_drop = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 5; i++) push_exp(4'b0001, 8'h10, 3'd0);
`else
        push_exp(4'b0001, 8'h10, 3'd0);
        push_exp(4'b0010, 8'h21, 3'd1);
        push_exp(4'b0100, 8'h32, 3'd2);
        push_exp(4'b1000, 8'h43, 3'd3);
        push_exp(4'b0001, 8'h10, 3'd0);
`endif
        applyStimulus(4'b1111);
        wait_sb_empty("drain_rotation", 200);
        req       = 4'b0000;
        auto_drop = 1'b1;
        wait_idle("idle_rotation", 40);

        // Transmitter busy in IDLE: no grant until tx_rdy rises
        model_on = 1'b0;
        tx_rdy   = 1'b0;
        req_data = 32'h0077_0000;
        applyStimulus(4'b0100);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput("no_gnt_tx_busy", 32'(gnt), 32'd0);
        end
        push_exp(4'b0100, 8'h77, 3'd2);
        tx_rdy   = 1'b1;
        model_on = 1'b1;
        wait_sb_empty("drain_delayed", 20);
        wait_idle("idle_delayed", 40);

        // Short req[2] pulse during WAIT_DONE is never granted
        req_data = 32'h0077_003C;
        push_exp(4'b0001, 8'h3C, 3'd0);
        applyStimulus(4'b0001);
        wait_wait_done("reach_wait_pulse", 20);
        g0 = gnt_seen;
        applyStimulus(req | 4'b0100);
        applyStimulus(req & 4'b1011);
        checkOutput("wait_hold_data", 32'(tx_data), 32'h3C);
        wait_idle("idle_pulse", 40);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("pulse_not_granted", 32'(gnt_seen - g0), 32'd0);
        checkOutput("data_stable_idle", 32'(tx_data), 32'h3C);

        // tx_rdy stuck high: launch timeout
        model_on = 1'b0;
        tx_rdy   = 1'b1;
        req_data = 32'hE100_0000;
        g0       = gnt_seen;
        we_cnt   = 0;
        err_cnt  = 0;
        push_exp(4'b1000, 8'hE1, 3'd3);
        applyStimulus(4'b1000);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (tx_write_en) we_cnt++;
            if (err) begin
                err_cnt++;
                checkOutput("busy_after_timeout", 32'(busy), 32'd0);
            end
        end
        checkOutput("timeout_we_cycles", 32'(we_cnt), 32'd8);
        checkOutput("timeout_err_pulses", 32'(err_cnt), 32'd1);
        checkOutput("timeout_single_gnt", 32'(gnt_seen - g0), 32'd1);
        model_on = 1'b1;

        // Reset in WAIT_DONE, then a post-reset grant held off by the busy transmitter
        req_data = 32'h0077_C300;
        push_exp(4'b0010, 8'hC3, 3'd1);
        applyStimulus(4'b0010);
        wait_wait_done("reach_wait_reset", 20);
        checkOutput("pre_reset_data", 32'(tx_data), 32'hC3);
        checkOutput("pre_reset_owner", 32'(owner), 32'd1);
        req = 4'b0110;
        push_exp(4'b0010, 8'hC3, 3'd1);
        push_exp(4'b0100, 8'h77, 3'd2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_data", 32'(tx_data), 32'd0);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_owner", 32'(owner), 32'd0);
        checkOutput("async_rst_we", 32'(tx_write_en), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (!tx_rdy && n < 30) begin
            @(negedge clk);
            #1;
            n++;
            if (!tx_rdy) checkOutput("no_gnt_after_reset", 32'(gnt), 32'd0);
        end
        checkOutput("tx_rdy_returned", 32'(tx_rdy), 32'd1);
        wait_sb_empty("drain_after_reset", 100);
        wait_idle("idle_final", 40);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter LAUNCH_TO, default 8: cycles allowed in LAUNCH for tx_rdy to fall; legal range 2..255.
REQ-003 The block SHALL use one clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock; all state changes occur on it.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req  in  NUM_REQ  per-requester byte request; level, held until the matching gnt.
REQ-007 req_data  in  8*NUM_REQ  packed bytes; requester i at bits [8i+7:8i].
REQ-008 gnt  out  NUM_REQ  one-hot, one-cycle acceptance pulse; zero otherwise.
REQ-009 tx_data  out  8  byte to uart_tx data input.
REQ-010 tx_write_en  out  1  start strobe to uart_tx write_en.
REQ-011 tx_rdy  in  1  from uart_tx rdy; high = transmitter idle.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 owner  out  3  index of the most recently granted requester.
REQ-014 err  out  1  one-cycle pulse on launch timeout.

Function
REQ-015 States SHALL be IDLE, LAUNCH and WAIT_DONE.
REQ-016 IDLE: when tx_rdy=1 and req!=0, the block SHALL select a winner, latch its byte into tx_data, set owner, pulse gnt[winner], and enter LAUNCH on the same edge.
REQ-017 IDLE with tx_rdy=0 SHALL NOT grant, regardless of req.
REQ-018 Round-robin: the search starts at pointer ptr and proceeds upward with wrap at NUM_REQ; the first set req wins; on grant, ptr becomes (winner+1) mod NUM_REQ.
REQ-019 Requests are not sticky: a req deasserted before its grant cycle is never granted.
REQ-020 LAUNCH: tx_write_en=1; when tx_rdy=0 is sampled, clear tx_write_en and enter WAIT_DONE.
REQ-021 LAUNCH: if tx_rdy stays 1 for LAUNCH_TO cycles, clear tx_write_en, pulse err, drop the byte and return to IDLE; ptr keeps its post-grant value.
REQ-022 WAIT_DONE: hold tx_data stable; enter IDLE when tx_rdy=1 is sampled.
REQ-023 tx_data SHALL change only on a grant edge; it SHALL be stable from the grant until the return to IDLE.
REQ-024 Latency: req set to gnt pulse = 1 cycle; gnt to tx_write_en=1 = 0 cycles (same edge).
REQ-025 Best-case grant rate: one grant per uart_tx frame; back-to-back requesters are served in rotating order with no idle gap beyond the single cycle for which tx_rdy reads 1.
REQ-026 A gnt pulse and err SHALL never be set in the same cycle; at most one gnt bit SHALL be set in any cycle.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE, with ptr=0, owner=0, tx_data=0x00, tx_write_en=0, gnt=0, busy=0, err=0.
REQ-028 Reset asserted mid-LAUNCH or mid-WAIT_DONE SHALL immediately force the REQ-027 values; the in-flight uart_tx frame is not aborted by this block.
REQ-029 After reset release, the first grant SHALL obey REQ-016/017, so a uart_tx still busy (tx_rdy=0) delays it.

Configuration
REQ-030 Macro UART_ARB_FIXED_PRIO_EN: when defined, the lowest-index set req always wins and ptr stays 0.
REQ-031 When the macro is undefined, the block SHALL use the round-robin scheme of REQ-018.
REQ-032 Every other behaviour SHALL be identical with and without the macro.

Verification
REQ-033 Scenario: req=0b0001, byte 0x5A, model tx_rdy -> gnt=0b0001 one cycle, tx_data=0x5A, tx_write_en=1 until tx_rdy=0, owner=0.
REQ-034 Scenario: req=0b1111 held, round-robin -> grant order 0,1,2,3,0; with UART_ARB_FIXED_PRIO_EN defined -> 0,0,0,0,0.
REQ-035 Scenario: tx_rdy tied 1 after a grant -> tx_write_en high exactly 8 cycles, err pulses once, busy=0 on the next cycle, no further gnt until req is reasserted.
REQ-036 Scenario: tx_rdy=0 in IDLE with req=0b0100 -> no gnt until tx_rdy=1, then gnt=0b0100.
REQ-037 Scenario: rst_n pulled low in WAIT_DONE with tx_data=0xC3 -> tx_data=0x00, busy=0, ptr=0 asynchronously.
REQ-038 Scenario: req[2] pulsed for 1 cycle while WAIT_DONE -> never granted.
